// File: rtl/arb_pkg.sv
// Shared types and constants for the 16-requester round-robin arbiter.
package arb_pkg;

    localparam int ARB_N     = 16;
    localparam int ARB_IDX_W = 4;

    // Arbiter FSM: waiting for a request, or holding a locked grant.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Modulo-16 increment used to advance the priority pointer past a winner.
    function automatic logic [ARB_IDX_W-1:0] idx_inc(input logic [ARB_IDX_W-1:0] v);
        return v + {{(ARB_IDX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/rr_pick_16.sv
// Combinational rotating-priority picker: returns the first set request
// at or above ptr, wrapping from 15 back to 0.
module rr_pick_16
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_IDX_W-1:0] ptr,
    output logic [ARB_IDX_W-1:0] idx,
    output logic                 found
);

    logic [2*ARB_N-1:0]   req_dbl;
    logic [ARB_N-1:0]     req_rot;
    logic [ARB_N-1:0]     lower_clear;
    logic [ARB_N-1:0]     first_hot;
    logic [ARB_IDX_W-1:0] rot_idx;

    // Rotate right by ptr so the pointer's requester lands at bit 0.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[ARB_N-1:0];

    // Fixed-priority find-first: bit gi wins only if every lower bit is clear.
    assign lower_clear[0] = 1'b1;
    genvar gi;
    generate
        for (gi = 1; gi < ARB_N; gi++) begin : g_lower
            assign lower_clear[gi] = lower_clear[gi-1] & ~req_rot[gi-1];
        end
        for (gi = 0; gi < ARB_N; gi++) begin : g_first
            assign first_hot[gi] = req_rot[gi] & lower_clear[gi];
        end
    endgenerate

    // Encode the one-hot winner in the rotated frame.
    always_comb begin
        rot_idx = '0;
        for (int i = 0; i < ARB_N; i++) begin
            if (first_hot[i]) begin
                rot_idx = ARB_IDX_W'(i);
            end
        end
    end

    // Un-rotate: adding ptr back is naturally modulo 16 in a 4-bit sum.
    assign idx   = rot_idx + ptr;
    assign found = |req;

endmodule

// File: rtl/rr_arbiter_16.sv
// Sixteen-requester round-robin arbiter. Picks one request, locks it until
// acknowledged, and presents the winner as a registered binary index.
module rr_arbiter_16
    import arb_pkg::*;
#(
    parameter logic [3:0] RESET_PTR = 4'd0
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        grant_ack,
    output logic [3:0]  grant_idx,
    output logic        grant_valid,
    output logic        busy_any
);

    arb_state_t           state_reg, state_next;
    logic [ARB_IDX_W-1:0] ptr_reg, ptr_next;
    logic [ARB_IDX_W-1:0] grant_idx_reg, grant_idx_next;
    logic                 grant_valid_reg, grant_valid_next;
    logic [ARB_IDX_W-1:0] pick_idx;
    logic                 pick_found;

    rr_pick_16 u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // State, pointer and output registers; reset abandons any pending grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ARB_IDLE;
            ptr_reg         <= RESET_PTR;
            grant_idx_reg   <= '0;
            grant_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            grant_idx_reg   <= grant_idx_next;
            grant_valid_reg <= grant_valid_next;
        end
    end

    // Next-state logic: the pointer only moves when a grant is acknowledged,
    // and acks seen while idle are ignored.
    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        grant_idx_next   = grant_idx_reg;
        grant_valid_next = grant_valid_reg;
        unique case (state_reg)
            ARB_IDLE: begin
                grant_valid_next = 1'b0;
                if (pick_found) begin
                    grant_idx_next   = pick_idx;
                    grant_valid_next = 1'b1;
                    state_next       = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (grant_ack) begin
                    grant_valid_next = 1'b0;
                    ptr_next         = idx_inc(grant_idx_reg);
                    state_next       = ARB_IDLE;
                end
            end
            default: begin
                state_next       = ARB_IDLE;
                grant_valid_next = 1'b0;
            end
        endcase
    end

    assign grant_idx   = grant_idx_reg;
    assign grant_valid = grant_valid_reg;
    assign busy_any    = |req;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed table-driven bench for rr_arbiter_16 with hand-computed expectations.
module tb_rr_arbiter_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        grant_ack;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        busy_any;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst_n;
        logic [15:0] req;
        logic        ack;
        logic        exp_valid;
        logic [3:0]  exp_idx;
        string       name;
    } vec_t;

    vec_t tbl[$];

    rr_arbiter_16 #(.RESET_PTR(4'd0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant_ack   (grant_ack),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .busy_any    (busy_any)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic [15:0] q, input logic a,
                                input logic ev, input logic [3:0] ei, input string nm);
        vec_t v;
        v.rst_n = r; v.req = q; v.ack = a; v.exp_valid = ev; v.exp_idx = ei; v.name = nm;
        tbl.push_back(v);
    endfunction

    // Drive one cycle's inputs at the falling edge, check after the rising edge.
    task automatic step(input logic r, input logic [15:0] q, input logic a,
                        input logic ev, input logic [3:0] ei, input string nm);
        @(negedge clk);
        rst_n = r; req = q; grant_ack = a;
        #1;
        n_cmp++;
        if (busy_any !== (q != 16'h0)) begin
            n_bad++;
            $display("FAIL %s busy_any: got %b want %b", nm, busy_any, (q != 16'h0));
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (grant_valid !== ev || grant_idx !== ei) begin
            n_bad++;
            $display("FAIL %s: got valid=%b idx=%0d want valid=%b idx=%0d",
                     nm, grant_valid, grant_idx, ev, ei);
        end else begin
            $display("ok   %s: req=%h ack=%b rst_n=%b -> valid=%b idx=%0d",
                     nm, q, a, r, grant_valid, grant_idx);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 16'h0; grant_ack = 1'b0;

        // Reset with all requests pending, then the first grant goes to ptr 0.
        add(0, 16'hFFFF, 0, 0, 0,  "reset_cyc0");
        add(0, 16'hFFFF, 0, 0, 0,  "reset_cyc1");
        add(1, 16'hFFFF, 0, 1, 0,  "first_grant");
        add(1, 16'hFFFF, 1, 0, 0,  "first_ack");
        // Re-reset, then rotation over bits 0,4,7.
        add(0, 16'h0091, 0, 0, 0,  "rot_reset");
        add(1, 16'h0091, 0, 1, 0,  "rot_g0");
        add(1, 16'h0091, 1, 0, 0,  "rot_a0");
        add(1, 16'h0091, 0, 1, 4,  "rot_g4");
        add(1, 16'h0091, 1, 0, 4,  "rot_a4");
        add(1, 16'h0091, 0, 1, 7,  "rot_g7");
        add(1, 16'h0091, 1, 0, 7,  "rot_a7");
        add(1, 16'h0091, 0, 1, 0,  "rot_g0_wrap");
        add(1, 16'h0091, 1, 0, 0,  "rot_a0_2");
        add(1, 16'h0091, 0, 1, 4,  "rot_g4_2");
        add(1, 16'h0091, 1, 0, 4,  "rot_a4_2");
        // Wrap-around via a grant to 14 (ptr becomes 15).
        add(1, 16'h4000, 0, 1, 14, "wrap_g14");
        add(1, 16'h4000, 1, 0, 14, "wrap_a14");
        add(1, 16'h8002, 0, 1, 15, "wrap_g15");
        add(1, 16'h8002, 1, 0, 15, "wrap_a15");
        add(1, 16'h8002, 0, 1, 1,  "wrap_g1");
        add(1, 16'h8002, 1, 0, 1,  "wrap_a1");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst_n, tbl[i].req, tbl[i].ack, tbl[i].exp_valid,
                 tbl[i].exp_idx, tbl[i].name);
        end

        // Lock: ptr=2, grant 3, then drop req[3]/raise req[9] with no ack.
        step(1, 16'h0008, 0, 1, 3, "lock_g3");
        for (int i = 0; i < 5; i++) begin
            step(1, 16'h0200, 0, 1, 3, $sformatf("lock_hold%0d", i));
        end
        step(1, 16'h0200, 1, 0, 3, "lock_ack");
        step(1, 16'h0200, 0, 1, 9, "lock_next9");
        step(1, 16'h0200, 1, 0, 9, "lock_ack9");

        // Spurious ack while idle: nothing moves, ptr stays 10.
        step(1, 16'h0000, 1, 0, 9, "spur_ack");
        step(1, 16'h0000, 0, 0, 9, "spur_idle");
        step(1, 16'h0020, 0, 1, 5, "spur_g5");
        step(1, 16'h0020, 1, 0, 5, "spur_a5");

        // Reset mid-grant: ptr=6, grant 6, then reset; ptr returns to 0.
        step(1, 16'h0040, 0, 1, 6, "mid_g6");
        step(0, 16'h0041, 0, 0, 0, "mid_reset");
        step(1, 16'h0041, 0, 1, 0, "mid_next0");
        step(1, 16'h0041, 1, 0, 0, "mid_ack0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
